// File: rtl/result_reader_pkg.sv
// Shared definitions for result_reader: display index codes and FSM state encoding.
package result_reader_pkg;

    localparam logic [1:0] IDX_REGA   = 2'd0;
    localparam logic [1:0] IDX_REGB   = 2'd1;
    localparam logic [1:0] IDX_OPCODE = 2'd2;
    localparam logic [1:0] IDX_BUFFER = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Display order wraps from the buffer entry back to register A.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/result_reader_rise_detect.sv
// rise_detect: registered rising-edge detector with synchronous active-high reset.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q, prev_d;

    always_comb begin
        prev_d = d_i;
        rise_o = d_i & ~prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/result_reader.sv
// result_reader: captures a processor-state snapshot on flagUC and shows one entry at a time.
// Define RESULT_READER_AUTOSCAN_EN to add the auto-advance timer (period AUTO_PERIOD cycles).
module result_reader
    import result_reader_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned AUTO_PERIOD = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flagUC,
    input  logic [DATA_W-1:0] tempRegA,
    input  logic [DATA_W-1:0] regB,
    input  logic [DATA_W-1:0] opcode,
    input  logic [DATA_W-1:0] buffer,
    input  logic              step,
    output logic [DATA_W-1:0] ledOutput,
    output logic [1:0]        choiceOut,
    output logic              valid,
    output logic              ackUC
);

    if (AUTO_PERIOD < 2) begin : g_bad_period
        $error("AUTO_PERIOD must be at least 2");
    end

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] rega_q, rega_d;
    logic [DATA_W-1:0] regb_q, regb_d;
    logic [DATA_W-1:0] opc_q, opc_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              ack_q, ack_d;
    logic              step_rise;
    logic [DATA_W-1:0] sel_val;

`ifdef RESULT_READER_AUTOSCAN_EN
    localparam int unsigned TIMER_W = $clog2(AUTO_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_PERIOD - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    rise_detect u_step_rise (
        .clk_i  (clock),
        .rst_i  (reset),
        .d_i    (step),
        .rise_o (step_rise)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        opc_d   = opc_q;
        buf_d   = buf_q;
        ack_d   = 1'b0;
`ifdef RESULT_READER_AUTOSCAN_EN
        timer_d = timer_q;
`endif
        // Capture has priority and swallows a coincident step edge.
        if (flagUC) begin
            rega_d  = tempRegA;
            regb_d  = regB;
            opc_d   = opcode;
            buf_d   = buffer;
            idx_d   = IDX_REGA;
            state_d = SHOW;
            ack_d   = 1'b1;
`ifdef RESULT_READER_AUTOSCAN_EN
            timer_d = '0;
`endif
        end else if (state_q == SHOW) begin
            if (step_rise) begin
                idx_d = next_idx(idx_q);
`ifdef RESULT_READER_AUTOSCAN_EN
                timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
                idx_d   = next_idx(idx_q);
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= IDX_REGA;
            rega_q  <= '0;
            regb_q  <= '0;
            opc_q   <= '0;
            buf_q   <= '0;
            ack_q   <= 1'b0;
`ifdef RESULT_READER_AUTOSCAN_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            opc_q   <= opc_d;
            buf_q   <= buf_d;
            ack_q   <= ack_d;
`ifdef RESULT_READER_AUTOSCAN_EN
            timer_q <= timer_d;
`endif
        end
    end

    always_comb begin
        sel_val = rega_q;
        unique case (idx_q)
            IDX_REGA:   sel_val = rega_q;
            IDX_REGB:   sel_val = regb_q;
            IDX_OPCODE: sel_val = opc_q;
            IDX_BUFFER: sel_val = buf_q;
            default:    sel_val = rega_q;
        endcase
        valid     = (state_q == SHOW);
        ledOutput = valid ? sel_val : '0;
        choiceOut = idx_q;
        ackUC     = ack_q;
    end

endmodule

// File: tb/tb_result_reader.sv
// Table-driven, scoreboarded bench for result_reader; covers the auto-scan build when
// RESULT_READER_AUTOSCAN_EN is defined.
module tb_result_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       flagUC;
    logic [7:0] tempRegA, regB, opcode, buffer;
    logic       step;
    logic [7:0] ledOutput;
    logic [1:0] choiceOut;
    logic       valid, ackUC;

    result_reader #(
        .DATA_W      (8),
        .AUTO_PERIOD (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flagUC    (flagUC),
        .tempRegA  (tempRegA),
        .regB      (regB),
        .opcode    (opcode),
        .buffer    (buffer),
        .step      (step),
        .ledOutput (ledOutput),
        .choiceOut (choiceOut),
        .valid     (valid),
        .ackUC     (ackUC)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        flg;
        logic        stp;
        logic [31:0] data;   // {A, B, opcode, buffer}
        logic [7:0]  led;
        logic [1:0]  ch;
        logic        v;
        logic        ack;
    } tv_t;

    typedef struct {
        int         row;
        logic [7:0] led;
        logic [1:0] ch;
        logic       v;
        logic       ack;
    } exp_t;

    tv_t  tv[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rst, input logic flg, input logic stp, input logic [31:0] data,
                       input logic [7:0] led, input logic [1:0] ch, input logic v,
                       input logic ack);
        tv_t t;
        t.rst = rst; t.flg = flg; t.stp = stp; t.data = data;
        t.led = led; t.ch = ch; t.v = v; t.ack = ack;
        tv.push_back(t);
    endtask

    task automatic check_out();
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: got output with empty expectation queue");
        end else begin
            e = exp_q.pop_front();
            if ({ledOutput, choiceOut, valid, ackUC} !== {e.led, e.ch, e.v, e.ack}) begin
                bad++;
                $display("FAIL row%0d: got led=%h ch=%0d v=%b ack=%b, want led=%h ch=%0d v=%b ack=%b",
                         e.row, ledOutput, choiceOut, valid, ackUC, e.led, e.ch, e.v, e.ack);
            end
        end
    endtask

    task automatic drive(input tv_t t, input int row);
        exp_t e;
        @(negedge clock);
        reset = t.rst; flagUC = t.flg; step = t.stp;
        {tempRegA, regB, opcode, buffer} = t.data;
        e.row = row; e.led = t.led; e.ch = t.ch; e.v = t.v; e.ack = t.ack;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check_out();
    endtask

    localparam logic [31:0] D0 = 32'h1234_0246;
    localparam logic [31:0] DF = 32'hFFFF_FFFF;

    initial begin
        int acks;
        reset = 1'b1; flagUC = 1'b0; step = 1'b0;
        {tempRegA, regB, opcode, buffer} = '0;

        // Reset with toggling flagUC/step, then a step edge while idle.
        add(1, 1, 0, D0, 8'h00, 0, 0, 0);
        add(1, 0, 1, D0, 8'h00, 0, 0, 0);
        add(1, 1, 1, D0, 8'h00, 0, 0, 0);
        add(0, 0, 0, D0, 8'h00, 0, 0, 0);
        add(0, 0, 1, D0, 8'h00, 0, 0, 0);
        add(0, 0, 0, D0, 8'h00, 0, 0, 0);
        // Capture, then inputs change without effect.
        add(0, 1, 0, D0, 8'h12, 0, 1, 1);
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
`ifdef RESULT_READER_AUTOSCAN_EN
        // Auto-advance every 4 cycles; a step at timer=2 restarts the period.
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
        add(0, 0, 0, DF, 8'h34, 1, 1, 0);
        add(0, 0, 0, DF, 8'h34, 1, 1, 0);
        add(0, 0, 0, DF, 8'h34, 1, 1, 0);
        add(0, 0, 1, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h46, 3, 1, 0);
        add(0, 0, 0, DF, 8'h46, 3, 1, 0);
        add(0, 0, 0, DF, 8'h46, 3, 1, 0);
        add(0, 0, 0, DF, 8'h46, 3, 1, 0);
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
        // Reset mid-scan; the timer must stay idle afterwards.
        add(1, 0, 0, DF, 8'h00, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, DF, 8'h00, 0, 0, 0);
`else
        // Four separated step pulses wrap the index.
        add(0, 0, 1, DF, 8'h34, 1, 1, 0);
        add(0, 0, 0, DF, 8'h34, 1, 1, 0);
        add(0, 0, 1, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h02, 2, 1, 0);
        add(0, 0, 1, DF, 8'h46, 3, 1, 0);
        add(0, 0, 0, DF, 8'h46, 3, 1, 0);
        add(0, 0, 1, DF, 8'h12, 0, 1, 0);
        add(0, 0, 0, DF, 8'h12, 0, 1, 0);
        // Step held for 10 cycles advances once.
        for (int i = 0; i < 10; i++) add(0, 0, 1, DF, 8'h34, 1, 1, 0);
        add(0, 0, 0, DF, 8'h34, 1, 1, 0);
        add(0, 0, 1, DF, 8'h02, 2, 1, 0);
        add(0, 0, 0, DF, 8'h02, 2, 1, 0);
        // Capture collides with a step edge at index 2.
        add(0, 1, 1, 32'h99AA_BBCC, 8'h99, 0, 1, 1);
        add(0, 0, 1, 32'h99AA_BBCC, 8'h99, 0, 1, 0);
        // flagUC held: recapture each cycle, last sample wins.
        add(0, 1, 0, 32'h55AA_BBCC, 8'h55, 0, 1, 1);
        add(0, 1, 0, 32'h66AA_BBCC, 8'h66, 0, 1, 1);
        add(0, 0, 0, 32'h77AA_BBCC, 8'h66, 0, 1, 0);
        add(0, 0, 1, 32'h77AA_BBCC, 8'hAA, 1, 1, 0);
        add(1, 0, 1, 32'h77AA_BBCC, 8'h00, 0, 0, 0);
        add(0, 0, 0, 32'h77AA_BBCC, 8'h00, 0, 0, 0);
        add(0, 0, 1, 32'h77AA_BBCC, 8'h00, 0, 0, 0);
`endif

        for (int i = 0; i < tv.size(); i++) drive(tv[i], i);

        // Single-cycle capture from IDLE: ack lasts exactly one cycle.
        @(negedge clock);
        reset = 1'b0; step = 1'b0; flagUC = 1'b1;
        {tempRegA, regB, opcode, buffer} = 32'h3C11_2233;
        @(posedge clock);
        #1;
        total++;
        if (ledOutput !== 8'h3C || valid !== 1'b1) begin
            bad++;
            $display("FAIL capture_3c: got led=%h v=%b, want led=3c v=1", ledOutput, valid);
        end
        acks = (ackUC === 1'b1) ? 1 : 0;
        @(negedge clock);
        flagUC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            if (ackUC === 1'b1) acks++;
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL ack_width: got %0d ack cycles, want 1", acks);
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
